plru_victim_select: RTL and testbench

- Per-set tree pseudo-LRU replacement unit for the set-associative caches.
- Tracks recency per set from access "touch" events.
- On a fill request, returns the way to replace. An invalid way always takes priority over the PLRU choice.
- Sits beside each cache's tag array; the victim way feeds the fill/writeback path.

---
 rtl/plru_victim_select.sv | 112 +++++++++++
 tb/tb_plru_victim_select.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/plru_victim_select.sv
// Per-set tree pseudo-LRU victim select: 1-cycle registered response, no backpressure (accepts every request).
// Optional PLRU_AUTO_TOUCH_EN: each victim request also marks the chosen way MRU in its set.
module plru_victim_select #(
  parameter int LOG_WAYS = 2,
  parameter int LOG_SETS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                touch_valid,
  input  logic [LOG_SETS-1:0] touch_set,
  input  logic [LOG_WAYS-1:0] touch_way,
  input  logic                victim_req,
  input  logic [LOG_SETS-1:0] victim_set,
  input  logic [2**LOG_WAYS-1:0] way_valid,
  output logic                victim_valid,
  output logic [LOG_WAYS-1:0] victim_way,
  output logic                victim_invalid
);

  localparam int WAYS  = 2**LOG_WAYS;
  localparam int SETS  = 2**LOG_SETS;
  localparam int NODES = WAYS - 1;
  localparam int NW    = LOG_WAYS + 1;

`ifdef PLRU_AUTO_TOUCH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef logic [NODES-1:0] tree_t;

  // Point every node on the root-to-way path away from that way.
  function automatic tree_t touch_path(input tree_t t, input logic [LOG_WAYS-1:0] way);
    tree_t               r;
    logic [NW-1:0]       node;
    logic [LOG_WAYS-1:0] w;
    r    = t;
    node = '0;
    w    = way;
    for (int l = 0; l < LOG_WAYS; l++) begin
      for (int n = 0; n < NODES; n++) begin
        if (node == NW'(n)) r[n] = ~w[LOG_WAYS-1];
      end
      node = {node[NW-2:0], 1'b0} + NW'(1) + NW'(w[LOG_WAYS-1]);
      w    = w << 1;
    end
    return r;
  endfunction

  // The bits followed from root to leaf spell out the way index, MSB first.
  function automatic logic [LOG_WAYS-1:0] plru_way(input tree_t t);
    logic [NW-1:0]       node;
    logic [LOG_WAYS-1:0] w;
    logic                b;
    node = '0;
    w    = '0;
    for (int l = 0; l < LOG_WAYS; l++) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++) begin
        if (node == NW'(n)) b = t[n];
      end
      w    = (w << 1) | LOG_WAYS'(b);
      node = {node[NW-2:0], 1'b0} + NW'(1) + NW'(b);
    end
    return w;
  endfunction

  tree_t               tree [SETS];
  tree_t               vic_tree;
  tree_t               auto_tree;
  tree_t               touch_base;
  tree_t               touch_tree;
  logic                all_valid;
  logic [LOG_WAYS-1:0] inv_way;
  logic [LOG_WAYS-1:0] sel_way;

  always_comb begin
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) inv_way = LOG_WAYS'(i);
    end
  end

  assign vic_tree  = tree[victim_set];
  assign all_valid = &way_valid;
  assign sel_way   = all_valid ? plru_way(vic_tree) : inv_way;
  assign auto_tree = touch_path(vic_tree, sel_way);

  // Explicit touch is layered on top of the auto-touch so its path nodes win.
  assign touch_base = (AUTO && victim_req && (victim_set == touch_set)) ? auto_tree
                                                                         : tree[touch_set];
  assign touch_tree = touch_path(touch_base, touch_way);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_invalid <= 1'b0;
    end else begin
      victim_valid <= victim_req;
      if (victim_req) begin
        victim_way     <= sel_way;
        victim_invalid <= ~all_valid;
      end
      if (AUTO && victim_req) tree[victim_set] <= auto_tree;
      if (touch_valid)        tree[touch_set]  <= touch_tree;
    end
  end

endmodule

// File: tb/tb_plru_victim_select.sv
// Directed plus random checks of plru_victim_select against a node-array PLRU reference model.
module tb_plru_victim_select;

  localparam int LW   = 2;
  localparam int LS   = 6;
  localparam int WAYS = 2**LW;
  localparam int SETS = 2**LS;

`ifdef PLRU_AUTO_TOUCH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          touch_valid;
  logic [LS-1:0] touch_set;
  logic [LW-1:0] touch_way;
  logic          victim_req;
  logic [LS-1:0] victim_set;
  logic [WAYS-1:0] way_valid;
  logic          victim_valid;
  logic [LW-1:0] victim_way;
  logic          victim_invalid;

  plru_victim_select #(.LOG_WAYS(LW), .LOG_SETS(LS)) dut (
    .clk           (clk),
    .reset         (reset),
    .touch_valid   (touch_valid),
    .touch_set     (touch_set),
    .touch_way     (touch_way),
    .victim_req    (victim_req),
    .victim_set    (victim_set),
    .way_valid     (way_valid),
    .victim_valid  (victim_valid),
    .victim_way    (victim_way),
    .victim_invalid(victim_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: node n has children 2n+1 / 2n+2, leaves follow node WAYS-2.
  int mt [SETS][WAYS-1];
  int e_vld, e_way, e_inv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_touch(input int s, input int w);
    int node = 0;
    for (int l = 0; l < LW; l++) begin
      int b = (w >> (LW - 1 - l)) & 1;
      mt[s][node] = 1 - b;
      node = 2 * node + 1 + b;
    end
  endtask

  function automatic int m_walk(input int s);
    int node = 0;
    for (int l = 0; l < LW; l++) node = 2 * node + 1 + mt[s][node];
    return node - (WAYS - 1);
  endfunction

  task automatic m_reset();
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < WAYS - 1; n++) mt[s][n] = 0;
    e_vld = 0; e_way = 0; e_inv = 0;
  endtask

  // One clock: drive inputs, advance the model, then check registered outputs.
  task automatic do_cycle(input bit rst, input bit tv, input int ts, input int tw,
                          input bit vr, input int vs, input int wv);
    reset       = rst;
    touch_valid = tv;
    touch_set   = LS'(ts);
    touch_way   = LW'(tw);
    victim_req  = vr;
    victim_set  = LS'(vs);
    way_valid   = WAYS'(wv);
    if (rst) begin
      m_reset();
    end else begin
      e_vld = vr;
      if (vr) begin
        if (wv != (1 << WAYS) - 1) begin
          e_inv = 1;
          e_way = 0;
          while ((wv >> e_way) & 1) e_way++;
        end else begin
          e_inv = 0;
          e_way = m_walk(vs);
        end
        if (AUTO) m_touch(vs, e_way);
      end
      if (tv) m_touch(ts, tw);
    end
    @(posedge clk);
    #1;
    chk("victim_valid", victim_valid, e_vld);
    chk("victim_way", victim_way, e_way);
    chk("victim_invalid", victim_invalid, e_inv);
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int seq_auto [4] = '{0, 2, 1, 3};
    m_reset();
    reset = 1'b1; touch_valid = 1'b0; touch_set = '0; touch_way = '0;
    victim_req = 1'b0; victim_set = '0; way_valid = '0;

    do_cycle(1, 0, 0, 0, 1, 5, 15);
    chk("reset_valid", victim_valid, 0);
    chk("reset_way", victim_way, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0);

    do_cycle(0, 0, 0, 0, 1, 5, 4'b1111);
    chk("plan_allvalid_way", victim_way, 0);
    chk("plan_allvalid_inv", victim_invalid, 0);
    do_cycle(0, 0, 0, 0, 1, 5, 4'b1011);
    chk("plan_inv1011_way", victim_way, 2);
    chk("plan_inv1011_inv", victim_invalid, 1);
    do_cycle(0, 0, 0, 0, 1, 5, 4'b0000);
    chk("plan_inv0000_way", victim_way, 0);
    chk("plan_inv0000_inv", victim_invalid, 1);
    idle();
    chk("hold_way", victim_way, 0);
    chk("hold_inv", victim_invalid, 1);

    for (int w = 0; w < 4; w++) do_cycle(0, 1, 3, w, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 3, 15);
    chk("plan_touch0123", victim_way, 0);

    do_cycle(0, 1, 9, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 9, 15);
    chk("plan_touch0", victim_way, 2);

    do_cycle(0, 1, 7, 0, 1, 7, 15);
    chk("plan_rbw_first", victim_way, 0);
    do_cycle(0, 0, 0, 0, 1, 7, 15);
    chk("plan_rbw_second", victim_way, 2);

    do_cycle(0, 1, 11, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 1, 11, 15);
    chk("reset_drop_valid", victim_valid, 0);
    idle();
    chk("reset_drop_nopulse", victim_valid, 0);
    do_cycle(0, 0, 0, 0, 1, 11, 15);
    chk("reset_tree_cleared", victim_way, 0);

    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 0, 0, 0, 1, 20, 15);
      chk("plan_seq", victim_way, AUTO ? seq_auto[i] : 0);
    end

    for (int i = 0; i < 400; i++) begin
      bit rst = ($urandom_range(0, 49) == 0);
      bit tv  = $urandom_range(0, 1);
      bit vr  = $urandom_range(0, 1);
      int wv  = $urandom_range(0, 1) ? 15 : $urandom_range(0, 15);
      do_cycle(rst, tv, $urandom_range(0, 3), $urandom_range(0, 3),
               vr, $urandom_range(0, 3), wv);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
